// File: rtl/arm_pkg.sv
// Shared opcode and flag-index definitions for the course ARM-subset datapath.
package arm_pkg;

  localparam logic [4:0] OP_AND   = 5'd0;
  localparam logic [4:0] OP_EOR   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_RSB   = 5'd3;
  localparam logic [4:0] OP_ADD   = 5'd4;
  localparam logic [4:0] OP_ADC   = 5'd5;
  localparam logic [4:0] OP_SBC   = 5'd6;
  localparam logic [4:0] OP_RSC   = 5'd7;
  localparam logic [4:0] OP_TST   = 5'd8;
  localparam logic [4:0] OP_TEQ   = 5'd9;
  localparam logic [4:0] OP_CMP   = 5'd10;
  localparam logic [4:0] OP_CMN   = 5'd11;
  localparam logic [4:0] OP_ORR   = 5'd12;
  localparam logic [4:0] OP_MOV   = 5'd13;
  localparam logic [4:0] OP_BIC   = 5'd14;
  localparam logic [4:0] OP_MVN   = 5'd15;
  localparam logic [4:0] OP_PASSA = 5'd16;
  localparam logic [4:0] OP_PASSB = 5'd17;
  localparam logic [4:0] OP_INC4  = 5'd18;
  localparam logic [4:0] OP_ADD4  = 5'd19;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_test_op(input logic [4:0] op);
    return (op >= OP_TST) && (op <= OP_CMN);
  endfunction

endpackage

// File: rtl/arm_alu_core.sv
// Combinational ALU: result and NZCV flags for the 16 data-processing ops and helpers.
module arm_alu_core
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  input  logic             cin,
  input  logic [3:0]       flags,
  output logic [WIDTH-1:0] r,
  output logic [3:0]       f,
  output logic             is_test,
  output logic             is_valid
);

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic             arith;
  logic [WIDTH:0]   sum;

  // All add/subtract ops share one adder; subtraction feeds the inverted operand.
  always_comb begin
    add_x   = a;
    add_y   = b;
    add_cin = 1'b0;
    arith   = 1'b0;
    r       = '0;
    case (op)
      OP_AND, OP_TST: r = a & b;
      OP_EOR, OP_TEQ: r = a ^ b;
      OP_SUB, OP_CMP: begin add_y = ~b; add_cin = 1'b1; arith = 1'b1; end
      OP_RSB:         begin add_x = b; add_y = ~a; add_cin = 1'b1; arith = 1'b1; end
      OP_ADD, OP_CMN: arith = 1'b1;
      OP_ADC:         begin add_cin = cin; arith = 1'b1; end
      OP_SBC:         begin add_y = ~b; add_cin = cin; arith = 1'b1; end
      OP_RSC:         begin add_x = b; add_y = ~a; add_cin = cin; arith = 1'b1; end
      OP_ORR:         r = a | b;
      OP_MOV:         r = b;
      OP_BIC:         r = a & ~b;
      OP_MVN:         r = ~b;
      OP_PASSA:       r = a;
      OP_PASSB:       r = b;
      OP_INC4:        r = a + WIDTH'(4);
      OP_ADD4:        r = a + b + WIDTH'(4);
      default:        r = '0;
    endcase

    sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    if (arith) r = sum[WIDTH-1:0];
  end

  // Logical ops keep the incoming C and V; arithmetic ops take them from the adder.
  always_comb begin
    f         = flags;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    if (arith) begin
      f[FLAG_C] = sum[WIDTH];
      f[FLAG_V] = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (r[WIDTH-1] != add_x[WIDTH-1]);
    end
  end

  assign is_test  = is_test_op(op);
  assign is_valid = (op <= OP_ADD4);

endmodule

// File: rtl/arm_alu.sv
// Registered ALU: captures result and flags one edge after the operands are presented.
module arm_alu
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       OP,
  input  logic [3:0]       FLAGS,
  input  logic             S,
  input  logic             ALU_OUT,
  output logic [WIDTH-1:0] Out,
  output logic [3:0]       FLAGS_OUT
);

  logic [WIDTH-1:0] r;
  logic [3:0]       f;
  logic             is_test;
  logic             is_valid;
  logic             out_load;
  logic             flag_load;

  arm_alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (A),
    .b        (B),
    .op       (OP),
    .cin      (FLAGS[FLAG_C]),
    .flags    (FLAGS),
    .r        (r),
    .f        (f),
    .is_test  (is_test),
    .is_valid (is_valid)
  );

  // Test ops never write the result but always write flags; INC4/ADD4 never touch flags.
  assign out_load  = ALU_OUT && is_valid && !is_test;
  assign flag_load = is_test ||
                     (S && is_valid && (OP != OP_INC4) && (OP != OP_ADD4));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Out       <= '0;
      FLAGS_OUT <= '0;
    end else begin
      if (out_load)  Out       <= r;
      if (flag_load) FLAGS_OUT <= f;
    end
  end

endmodule

// File: tb/tb_arm_alu.sv
// Self-checking bench for arm_alu: directed literal cases plus randomized ops against a
// plain-arithmetic reference model.
module tb_arm_alu;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] A, B;
  logic [4:0]  OP;
  logic [3:0]  FLAGS;
  logic        S, ALU_OUT;
  logic [31:0] Out;
  logic [3:0]  FLAGS_OUT;

  logic [31:0] exp_out;
  logic [3:0]  exp_flags;
  bit          check_en;
  int          vectors;
  int          miscompares;

  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  arm_alu #(.WIDTH(32)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .FLAGS     (FLAGS),
    .S         (S),
    .ALU_OUT   (ALU_OUT),
    .Out       (Out),
    .FLAGS_OUT (FLAGS_OUT)
  );

  always #5 Clk = ~Clk;

  // Reference: exact integer arithmetic, C as "no unsigned wrap/borrow", V as signed range check.
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                                  input logic [3:0] fl, output logic [31:0] r, output logic [3:0] f);
    longint ua, ub, sa, sb, ci, bw, full, sres;
    bit c, v, arith;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = longint'(fl[1]);
    bw = 1 - ci;
    full = 0; sres = 0; c = 0; arith = 1;
    r = 32'd0;
    case (op)
      5'd2, 5'd10: begin full = ua - ub;      c = (ua >= ub);      sres = sa - sb; end
      5'd3:        begin full = ub - ua;      c = (ub >= ua);      sres = sb - sa; end
      5'd4, 5'd11: begin full = ua + ub;      c = (full > 64'hFFFFFFFF); sres = sa + sb; end
      5'd5:        begin full = ua + ub + ci; c = (full > 64'hFFFFFFFF); sres = sa + sb + ci; end
      5'd6:        begin full = ua - ub - bw; c = (ua >= ub + bw); sres = sa - sb - bw; end
      5'd7:        begin full = ub - ua - bw; c = (ub >= ua + bw); sres = sb - sa - bw; end
      default: begin
        arith = 0;
        case (op)
          5'd0, 5'd8: r = a & b;
          5'd1, 5'd9: r = a ^ b;
          5'd12:      r = a | b;
          5'd13:      r = b;
          5'd14:      r = a & ~b;
          5'd15:      r = ~b;
          5'd16:      r = a;
          5'd17:      r = b;
          5'd18:      r = a + 32'd4;
          5'd19:      r = a + b + 32'd4;
          default:    r = 32'd0;
        endcase
      end
    endcase
    if (arith) r = full[31:0];
    v = (sres > SMAX) || (sres < SMIN);
    if (arith) f = {r[31], (r == 32'd0), c, v};
    else       f = {r[31], (r == 32'd0), fl[1], fl[0]};
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                               input logic [3:0] fl, input logic s, input logic ao);
    logic [31:0] r;
    logic [3:0]  f;
    bit          is_test, ld_out, ld_fl;
    A = a; B = b; OP = op; FLAGS = fl; S = s; ALU_OUT = ao;
    ref_alu(a, b, op, fl, r, f);
    is_test = (op >= 5'd8) && (op <= 5'd11);
    ld_out  = ao && (op <= 5'd19) && !is_test;
    ld_fl   = is_test || (s && ((op <= 5'd7) || ((op >= 5'd12) && (op <= 5'd17))));
    @(posedge Clk);
    #1;
    if (ld_out) exp_out   = r;
    if (ld_fl)  exp_flags = f;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] eo, input logic [3:0] ef);
    vectors++;
    if (Out !== eo || FLAGS_OUT !== ef || exp_out !== eo || exp_flags !== ef) begin
      miscompares++;
      $display("[TB] FAIL %s: Out=%h FLAGS_OUT=%b model=%h/%b required Out=%h FLAGS_OUT=%b",
               name, Out, FLAGS_OUT, exp_out, exp_flags, eo, ef);
    end
  endtask

  // Reset asserted mid-cycle and released mid-cycle, away from both clock edges.
  task automatic pulseReset();
    #2;
    Reset_n   = 1'b0;
    exp_out   = 32'd0;
    exp_flags = 4'd0;
    @(negedge Clk);
    #2;
    Reset_n = 1'b1;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h00000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h7FFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'($urandom_range(0, 8));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge Clk) begin
    if (check_en) begin
      vectors++;
      if (Out !== exp_out || FLAGS_OUT !== exp_flags) begin
        miscompares++;
        $display("[TB] FAIL cycle_compare @%0t: Out=%h FLAGS_OUT=%b expected Out=%h FLAGS_OUT=%b",
                 $time, Out, FLAGS_OUT, exp_out, exp_flags);
      end
    end
  end

  initial begin
    logic [4:0] op;
    vectors = 0; miscompares = 0; check_en = 0;
    exp_out = 32'd0; exp_flags = 4'd0;
    A = '0; B = '0; OP = '0; FLAGS = '0; S = 0; ALU_OUT = 0;
    Reset_n = 1'b0;
    #1;
    checkOutput("reset_initial", 32'd0, 4'b0000);
    @(negedge Clk);
    Reset_n  = 1'b1;
    check_en = 1;

    applyStimulus(32'h7FFFFFFF, 32'd1, 5'd4, 4'b0000, 1, 1);
    checkOutput("add_overflow", 32'h80000000, 4'b1001);

    #2;
    Reset_n   = 1'b0;
    exp_out   = 32'd0;
    exp_flags = 4'd0;
    #1;
    checkOutput("async_reset", 32'd0, 4'b0000);
    @(negedge Clk);
    #2;
    Reset_n = 1'b1;
    applyStimulus(32'h7FFFFFFF, 32'd1, 5'd4, 4'b0000, 0, 0);
    checkOutput("no_load_after_reset", 32'd0, 4'b0000);

    applyStimulus(32'd5, 32'd5, 5'd2, 4'b0000, 1, 1);
    checkOutput("sub_equal", 32'd0, 4'b0110);
    applyStimulus(32'd3, 32'd5, 5'd2, 4'b0000, 1, 1);
    checkOutput("sub_borrow", 32'hFFFFFFFE, 4'b1000);

    applyStimulus(32'hFFFFFFFF, 32'd0, 5'd5, 4'b0010, 1, 1);
    checkOutput("adc_carry_in", 32'd0, 4'b0110);
    applyStimulus(32'd10, 32'd3, 5'd6, 4'b0000, 1, 1);
    checkOutput("sbc_no_carry", 32'd6, 4'b0010);

    applyStimulus(32'd1, 32'd2, 5'd10, 4'b0000, 0, 1);
    checkOutput("cmp_no_s", 32'd6, 4'b1000);
    applyStimulus(32'd0, 32'd0, 5'd12, 4'b0000, 0, 1);
    checkOutput("orr_no_s", 32'd0, 4'b1000);

    applyStimulus(32'h000000F0, 32'h0000000F, 5'd0, 4'b0011, 1, 1);
    checkOutput("and_cv_pass", 32'd0, 4'b0111);
    applyStimulus(32'h00000100, 32'd0, 5'd18, 4'b0000, 1, 1);
    checkOutput("inc4", 32'h00000104, 4'b0111);
    applyStimulus(32'hDEADBEEF, 32'h12345678, 5'd25, 4'b1111, 1, 1);
    checkOutput("reserved_op", 32'h00000104, 4'b0111);

    for (int i = 0; i < 600; i++) begin
      op = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 19)) : 5'($urandom_range(20, 31));
      applyStimulus(pickOperand(), pickOperand(), op, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 49) == 0) pulseReset();
    end

    @(negedge Clk);
    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
